// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Requests are granted round-robin, issued through a registered ALU input
// stage, and the result is returned on the winner's response channel.
module alu_arbiter #(
  parameter int FIRST_GRANT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_ctrl,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_ctrl,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_r,
  output logic [31:0] rsp0_r2,
  output logic        rsp0_z,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_r,
  output logic [31:0] rsp1_r2,
  output logic        rsp1_z,
  output logic        rsp1_err,
  output logic [5:0]  alu_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_r,
  input  logic [31:0] alu_r2,
  input  logic        alu_z,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // last_grant starts as the opposite of FIRST_GRANT so the first contested
  // arbitration goes to FIRST_GRANT.
  localparam logic LAST_GRANT_INIT = (FIRST_GRANT == 0) ? 1'b1 : 1'b0;

  state_t      state;
  state_t      state_next;
  logic        last_grant;
  logic        gnt;
  logic        err;
  logic        any_valid;
  logic        win;
  logic        accept;
  logic        rsp_done;
  logic [5:0]  sel_ctrl;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

  // Legal opcode set is 0x00-0x04 and 0x06-0x14.
  function automatic logic is_legal(input logic [5:0] op);
    return (op <= 6'h04) || ((op >= 6'h06) && (op <= 6'h14));
  endfunction

  // Round-robin winner: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      win = ~last_grant;
    end else begin
      win = req1_valid;
    end
    sel_ctrl = win ? req1_ctrl : req0_ctrl;
    sel_a    = win ? req1_a    : req0_a;
    sel_b    = win ? req1_b    : req0_b;
    accept   = (state == IDLE) && any_valid;
    rsp_done = (state == RESP) && (gnt ? rsp1_ready : rsp0_ready);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and request handshake; ready only ever rises in IDLE.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          req0_ready = ~win;
          req1_ready = win;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered ALU drive, grant id and illegal-opcode flag, loaded on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ctrl <= 6'd0;
      alu_a    <= 32'd0;
      alu_b    <= 32'd0;
      gnt      <= 1'b0;
      err      <= 1'b0;
    end else if (accept) begin
      alu_ctrl <= sel_ctrl;
      alu_a    <= sel_a;
      alu_b    <= sel_b;
      gnt      <= win;
      err      <= ~is_legal(sel_ctrl);
    end
  end

  // Fairness history: updated only when a response completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= LAST_GRANT_INIT;
    end else if (rsp_done) begin
      last_grant <= gnt;
    end
  end

  // busy mirrors the registered FSM state so it is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
    end
  end

  // Requester 0 response register: captured at the end of EXEC, held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_r     <= 32'd0;
      rsp0_r2    <= 32'd0;
      rsp0_z     <= 1'b0;
      rsp0_err   <= 1'b0;
    end else if ((state == EXEC) && !gnt) begin
      rsp0_valid <= 1'b1;
      rsp0_r     <= alu_r;
      rsp0_r2    <= alu_r2;
      rsp0_z     <= alu_z;
      rsp0_err   <= err;
    end else if (rsp_done && !gnt) begin
      rsp0_valid <= 1'b0;
    end
  end

  // Requester 1 response register: captured at the end of EXEC, held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp1_valid <= 1'b0;
      rsp1_r     <= 32'd0;
      rsp1_r2    <= 32'd0;
      rsp1_z     <= 1'b0;
      rsp1_err   <= 1'b0;
    end else if ((state == EXEC) && gnt) begin
      rsp1_valid <= 1'b1;
      rsp1_r     <= alu_r;
      rsp1_r2    <= alu_r2;
      rsp1_z     <= alu_z;
      rsp1_err   <= err;
    end else if (rsp_done && gnt) begin
      rsp1_valid <= 1'b0;
    end
  end

endmodule
